// File: rtl/pipe_mem_access.sv
// pipe_mem_access
// MEM-stage data-memory access unit. Turns load/store control from EX/MEM
// into a single req/ack bus transaction and holds the pipeline until the
// bus completes (or times out). Load data is sign/zero extended for MEM/WB.
//
// Ports:
//   clk, rst                  pipeline clock (rising), async active-high reset
//   mem_read_MEM/mem_write_MEM load / store strobes (store wins if both set)
//   mem_type_MEM              access size and signedness
//   alu_MEM                   effective byte address
//   store_data_MEM            right-aligned store data
//   dm_req/dm_we/dm_addr/dm_be/dm_wdata   registered bus request
//   dm_rdata/dm_ack           bus response
//   DM_rdata_MEM              extended load result (non-zero only in DONE)
//   stall_MEM                 freeze upstream stages and MEM/WB
//   misalign_MEM              misaligned or illegal access (combinational)
//   bus_err_MEM               ack timeout, flagged in the DONE cycle

module pipe_mem_access #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_MEM,
    input  logic        mem_write_MEM,
    input  logic [2:0]  mem_type_MEM,
    input  logic [31:0] alu_MEM,
    input  logic [31:0] store_data_MEM,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic [31:0] DM_rdata_MEM,
    output logic        stall_MEM,
    output logic        misalign_MEM,
    output logic        bus_err_MEM
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] T_W  = 3'b000;
    localparam logic [2:0] T_H  = 3'b001;
    localparam logic [2:0] T_HU = 3'b010;
    localparam logic [2:0] T_B  = 3'b011;
    localparam logic [2:0] T_BU = 3'b100;

    // Counter sized for the largest legal ACK_TIMEOUT.
    localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [31:0] cap_q;
    logic        err_q;
    logic [2:0]  type_q;
    logic [1:0]  off_q;
    logic        dm_req_q, dm_we_q;
    logic [31:0] dm_addr_q, dm_wdata_q;
    logic [3:0]  dm_be_q;

    logic        access, is_store, misalign, go;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] ext;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    assign access   = mem_read_MEM | mem_write_MEM;
    assign is_store = mem_write_MEM;

    // Illegal type for the direction is folded into misalign so it never
    // reaches the bus.
    always_comb begin
        misalign = 1'b0;
        if (access) begin
            unique case (mem_type_MEM)
                T_W:       misalign = (alu_MEM[1:0] != 2'b00);
                T_H:       misalign = alu_MEM[0];
                T_HU:      misalign = is_store | alu_MEM[0];
                T_B:       misalign = 1'b0;
                T_BU:      misalign = is_store;
                default:   misalign = 1'b1;
            endcase
        end
    end

    assign go = access & ~misalign;

    // Lane enables and replicated store data for the request.
    always_comb begin
        be_d    = 4'b0000;
        wdata_d = 32'h0;
        unique case (mem_type_MEM)
            T_W:        be_d = 4'b1111;
            T_H, T_HU:  be_d = alu_MEM[1] ? 4'b1100 : 4'b0011;
            default:    be_d = 4'b0001 << alu_MEM[1:0];
        endcase
        if (is_store) begin
            unique case (mem_type_MEM)
                T_W:     wdata_d = store_data_MEM;
                T_H:     wdata_d = {2{store_data_MEM[15:0]}};
                default: wdata_d = {4{store_data_MEM[7:0]}};
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cap_q      <= '0;
            err_q      <= 1'b0;
            type_q     <= '0;
            off_q      <= '0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_be_q    <= '0;
            dm_wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q    <= REQ;
                        cnt_q      <= '0;
                        err_q      <= 1'b0;
                        type_q     <= mem_type_MEM;
                        off_q      <= alu_MEM[1:0];
                        dm_req_q   <= 1'b1;
                        dm_we_q    <= is_store;
                        dm_addr_q  <= {alu_MEM[31:2], 2'b00};
                        dm_be_q    <= be_d;
                        dm_wdata_q <= wdata_d;
                    end
                end
                REQ: begin
                    if (dm_ack) begin
                        // Stores complete with a zero capture so DONE shows 0.
                        cap_q    <= dm_we_q ? 32'h0 : dm_rdata;
                        dm_req_q <= 1'b0;
                        dm_we_q  <= 1'b0;
                        state_q  <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        cap_q    <= '0;
                        err_q    <= 1'b1;
                        dm_req_q <= 1'b0;
                        dm_we_q  <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Lane extraction from the captured word using the latched offset/type.
    always_comb begin
        sel_b = cap_q[7:0];
        unique case (off_q)
            2'd0: sel_b = cap_q[7:0];
            2'd1: sel_b = cap_q[15:8];
            2'd2: sel_b = cap_q[23:16];
            2'd3: sel_b = cap_q[31:24];
            default: sel_b = cap_q[7:0];
        endcase
        sel_h = off_q[1] ? cap_q[31:16] : cap_q[15:0];
        ext   = 32'h0;
        unique case (type_q)
            T_W:     ext = cap_q;
            T_H:     ext = {{16{sel_h[15]}}, sel_h};
            T_HU:    ext = {16'h0, sel_h};
            T_B:     ext = {{24{sel_b[7]}}, sel_b};
            T_BU:    ext = {24'h0, sel_b};
            default: ext = 32'h0;
        endcase
    end

    assign dm_req       = dm_req_q;
    assign dm_we        = dm_we_q;
    assign dm_addr      = dm_addr_q;
    assign dm_be        = dm_be_q;
    assign dm_wdata     = dm_wdata_q;
    assign DM_rdata_MEM = (state_q == DONE) ? ext : 32'h0;
    // Reset releases the pipeline immediately, even with an access pending.
    assign stall_MEM    = ~rst & ((state_q == REQ) | ((state_q == IDLE) & go));
    assign misalign_MEM = misalign;
    assign bus_err_MEM  = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_pipe_mem_access.sv
// Testbench for pipe_mem_access: directed cases plus randomized accesses
// checked against a word-array memory model with arithmetic lane handling.

module tb_pipe_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_MEM, mem_write_MEM;
    logic [2:0]  mem_type_MEM;
    logic [31:0] alu_MEM, store_data_MEM;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] DM_rdata_MEM;
    logic        stall_MEM, misalign_MEM, bus_err_MEM;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    bit [31:0] mem [bit [29:0]];

    pipe_mem_access #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_read_MEM(mem_read_MEM), .mem_write_MEM(mem_write_MEM),
        .mem_type_MEM(mem_type_MEM), .alu_MEM(alu_MEM),
        .store_data_MEM(store_data_MEM),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .DM_rdata_MEM(DM_rdata_MEM), .stall_MEM(stall_MEM),
        .misalign_MEM(misalign_MEM), .bus_err_MEM(bus_err_MEM)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit [31:0] rd_word(input bit [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return {a[31:2], 2'b00} ^ 32'hA5C3_0F96;
    endfunction

    function automatic bit is_mis(input bit wr, input bit [2:0] t, input bit [31:0] a);
        if (wr) begin
            if (!(t == 0 || t == 1 || t == 3)) return 1'b1;
        end else if (t > 4) return 1'b1;
        if (t == 0) return (a % 4) != 0;
        if (t == 1 || t == 2) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic int size_of(input bit [2:0] t);
        if (t == 0) return 4;
        if (t <= 2) return 2;
        return 1;
    endfunction

    function automatic bit [63:0] mask_of(input int sz);
        return (64'd1 << (8 * sz)) - 64'd1;
    endfunction

    function automatic bit [31:0] load_val(input bit [2:0] t, input bit [31:0] a, input bit [31:0] w);
        int sz = size_of(t);
        bit [63:0] m = mask_of(sz);
        bit [63:0] v = ({32'h0, w} >> (8 * (a % 4))) & m;
        if ((t == 1 || t == 3) && v[8 * sz - 1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic bit [31:0] rep_data(input int sz, input bit [31:0] sd);
        bit [63:0] lane = {32'h0, sd} & mask_of(sz);
        if (sz == 4) return sd;
        if (sz == 2) return lane[31:0] * 32'h0001_0001;
        return lane[31:0] * 32'h0101_0101;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        mem_read_MEM = 0; mem_write_MEM = 0; mem_type_MEM = 0;
        alu_MEM = 0; store_data_MEM = 0;
    endtask

    task automatic drive(input bit rd, input bit wr, input bit [2:0] t,
                         input bit [31:0] a, input bit [31:0] sd);
        mem_read_MEM = rd; mem_write_MEM = wr; mem_type_MEM = t;
        alu_MEM = a; store_data_MEM = sd;
    endtask

    // Aligned access; entered and left on a negedge with the DUT idle.
    task automatic do_access(input bit rd, input bit wr, input bit [2:0] t,
                             input bit [31:0] a, input bit [31:0] sd, input int wt);
        int sz = size_of(t);
        int sh = 8 * (a % 4);
        bit [31:0] w = rd_word(a);
        bit [3:0] ebe = 4'(((1 << sz) - 1) << (a % 4));
        bit [63:0] m;
        drive(rd, wr, t, a, sd);
        #1;
        chk("idle_stall", stall_MEM, 1);
        chk("idle_mis", misalign_MEM, 0);
        @(posedge clk); @(negedge clk);
        chk("req", dm_req, 1);
        chk("req_we", dm_we, wr);
        chk("req_addr", dm_addr, a & ~32'h3);
        chk("req_be", dm_be, ebe);
        if (wr) chk("req_wdata", dm_wdata, rep_data(sz, sd));
        chk("req_stall", stall_MEM, 1);
        chk("req_rdata_zero", DM_rdata_MEM, 0);
        repeat (wt) begin
            @(posedge clk); @(negedge clk);
            chk("req_hold", dm_req, 1);
            chk("req_hold_addr", dm_addr, a & ~32'h3);
            chk("req_hold_stall", stall_MEM, 1);
        end
        dm_ack = 1; dm_rdata = wr ? $urandom : w;
        @(posedge clk); @(negedge clk);
        dm_ack = 0; dm_rdata = $urandom;
        chk("done_stall", stall_MEM, 0);
        chk("done_req", dm_req, 0);
        chk("done_err", bus_err_MEM, 0);
        chk("done_data", DM_rdata_MEM, wr ? 32'h0 : load_val(t, a, w));
        if (wr) begin
            m = mask_of(sz) << sh;
            mem[a[31:2]] = (w & ~m[31:0]) | (32'(({32'h0, sd} & mask_of(sz)) << sh));
        end
        @(posedge clk); @(negedge clk);
        chk("idle_after_data", DM_rdata_MEM, 0);
        idle_inputs();
    endtask

    task automatic do_mis(input bit rd, input bit wr, input bit [2:0] t, input bit [31:0] a);
        drive(rd, wr, t, a, $urandom);
        #1;
        chk("mis_flag", misalign_MEM, 1);
        chk("mis_stall", stall_MEM, 0);
        chk("mis_data", DM_rdata_MEM, 0);
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("mis_noreq", dm_req, 0);
            chk("mis_stall_hold", stall_MEM, 0);
        end
        idle_inputs();
    endtask

    initial begin
        int unsigned t0;
        bit [31:0] ra;
        bit [2:0] rt;
        bit [1:0] rw;

        rst = 1; dm_ack = 0; dm_rdata = 0;
        idle_inputs();
        #1;
        chk("rst_req", dm_req, 0);
        chk("rst_we", dm_we, 0);
        chk("rst_be", dm_be, 0);
        chk("rst_wdata", dm_wdata, 0);
        chk("rst_addr", dm_addr, 0);
        chk("rst_rdata", DM_rdata_MEM, 0);
        chk("rst_stall", stall_MEM, 0);
        chk("rst_err", bus_err_MEM, 0);
        @(negedge clk); rst = 0;
        @(negedge clk);

        // Reset while a request is outstanding.
        drive(1, 0, 3'b000, 32'h180, 0);
        @(posedge clk); @(negedge clk);
        chk("pre_rst_req", dm_req, 1);
        rst = 1;
        #1;
        chk("mid_rst_req", dm_req, 0);
        chk("mid_rst_stall", stall_MEM, 0);
        idle_inputs();
        @(negedge clk); rst = 0;
        dm_ack = 1; dm_rdata = 32'hFFFF_FFFF;
        @(posedge clk); @(negedge clk);
        dm_ack = 0;
        chk("late_ack_data", DM_rdata_MEM, 0);
        chk("late_ack_req", dm_req, 0);
        @(posedge clk); @(negedge clk);
        chk("late_ack_data2", DM_rdata_MEM, 0);

        // Directed loads/stores.
        mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        do_access(1, 0, 3'b000, 32'h100, 0, 0);
        do_access(0, 1, 3'b000, 32'h100, 32'h8011_2233, 1);
        do_access(1, 0, 3'b011, 32'h103, 0, 0);
        do_access(1, 0, 3'b100, 32'h103, 0, 0);
        do_access(1, 0, 3'b001, 32'h102, 0, 2);
        do_access(1, 0, 3'b010, 32'h102, 0, 0);
        do_access(0, 1, 3'b011, 32'h201, 32'h0000_00A5, 0);
        do_access(0, 1, 3'b001, 32'h202, 32'h0000_1234, 3);
        do_access(1, 1, 3'b000, 32'h204, 32'hCAFE_F00D, 0);
        do_access(1, 0, 3'b000, 32'h204, 0, 1);

        // Misaligned / illegal.
        do_mis(1, 0, 3'b000, 32'h102);
        do_mis(1, 0, 3'b001, 32'h101);
        do_mis(0, 1, 3'b010, 32'h200);
        do_mis(1, 0, 3'b111, 32'h200);

        // Timeout: ACK_TIMEOUT=4 gives four REQ cycles.
        drive(1, 0, 3'b000, 32'h104, 0);
        @(posedge clk); @(negedge clk);
        repeat (4) begin
            chk("to_req", dm_req, 1);
            chk("to_stall", stall_MEM, 1);
            @(posedge clk); @(negedge clk);
        end
        chk("to_err", bus_err_MEM, 1);
        chk("to_data", DM_rdata_MEM, 0);
        chk("to_stall_done", stall_MEM, 0);
        chk("to_req_done", dm_req, 0);
        @(posedge clk); @(negedge clk);
        chk("to_err_clear", bus_err_MEM, 0);
        idle_inputs();

        // Back-to-back zero-wait pair: 3 cycles each.
        t0 = cyc;
        do_access(1, 0, 3'b000, 32'h208, 0, 0);
        do_access(0, 1, 3'b000, 32'h20C, 32'h1357_9BDF, 0);
        chk("b2b_cycles", cyc - t0, 6);

        // Randomized accesses against the model.
        for (int i = 0; i < 40; i++) begin
            ra = 32'h200 + $urandom_range(0, 63);
            rw = 2'($urandom_range(1, 3));
            rt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            if (is_mis(rw[1], rt, ra)) do_mis(rw[0], rw[1], rt, ra);
            else do_access(rw[0], rw[1], rt, ra, $urandom, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
